arith_encoder_frame_ctrl: RTL and testbench
===========================================

// Module: arith_encoder_frame_ctrl
// PURPOSE
//  Frame-level sequencer in front of arithmetic_encoder. Takes a valid/ready stream of (fl, fh, symbol, nsyms, last)
//  beats and issues one symbol per cycle to the encoder datapath. After the last symbol it waits out the encoder
//  pipeline, then requests and awaits the final flush. Reports frame completion and the symbol count.
// PARAMETERS
//  RANGE_WIDTH   16  width of fl/fh (matches GENERAL_RANGE_WIDTH)
//  SYMBOL_WIDTH  4   width of symbol; nsyms is SYMBOL_WIDTH+1 bits
//  PIPE_DEPTH    4   encoder cycles from symbol issue to stable range/low (0..15)
//  CNT_WIDTH     16  width of frame symbol counter
// PORTS
//  general_clk  in   1               single clock, all logic rising-edge
//  reset        in   1               synchronous, active-low
//  in_valid     in   1               input beat valid
//  in_ready     out  1               controller accepts beat this cycle
//  in_fl        in   RANGE_WIDTH     cumulative freq low
//  in_fh        in   RANGE_WIDTH     cumulative freq high
//  in_symbol    in   SYMBOL_WIDTH    symbol index
//  in_nsyms     in   SYMBOL_WIDTH+1  alphabet size
//  in_last      in   1               beat is final symbol of frame
//  enc_valid    out  1               enc_* carry a new symbol this cycle
//  enc_fl       out  RANGE_WIDTH     to encoder general_fl
//  enc_fh       out  RANGE_WIDTH     to encoder general_fh
//  enc_symbol   out  SYMBOL_WIDTH    to encoder general_symbol
//  enc_nsyms    out  SYMBOL_WIDTH+1  to encoder general_nsyms
//  flush_req    out  1               request final encoder flush (level)
//  flush_done   in   1               flush finished (1-cycle pulse)
//  frame_done   out  1               1-cycle pulse, frame fully encoded
//  busy         out  1               state != IDLE
//  sym_count    out  CNT_WIDTH       symbols issued in current/last frame
//  err_sym      out  1               sticky illegal-symbol flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0 at edge): state IDLE. All outputs 0, incl. enc_*, sym_count, err_sym. in_ready is 0 while reset==0.
//  - FSM: IDLE -> RUN -> DRAIN -> FLUSH -> DONE -> IDLE.
//  - in_ready = 1 in IDLE and RUN, else 0. Accept = in_valid & in_ready.
//  - IDLE: on accept, clear sym_count to 1 (or 0 if dropped), issue the beat, go RUN; if in_last, go DRAIN directly.
//  - RUN: each accept is issued and increments sym_count. sym_count saturates at all-ones. Accept with in_last -> DRAIN.
//  - Issue latency is 1 cycle: accepted beat registers onto enc_* with enc_valid=1 the next cycle.
//    enc_* hold their value while enc_valid=0. No backpressure from the encoder; full rate is 1 symbol/cycle.
//  - DRAIN: down-counter is loaded with PIPE_DEPTH on the in_last accept and decrements each cycle.
//    Go FLUSH when the count is 0. PIPE_DEPTH=0 -> FLUSH on the cycle after DRAIN entry.
//  - FLUSH: flush_req=1 until flush_done is sampled high, then DONE. flush_done outside FLUSH is ignored.
//  - DONE: frame_done=1 for exactly one cycle, then IDLE. sym_count holds until the next frame's first accept.
//  - Reset mid-frame aborts: no frame_done, no flush_req, counters cleared.
// CONFIGURATION
//  - Macro ARITH_CTRL_SYMCHK_EN, when defined:
//    - An accepted beat with in_symbol >= in_nsyms, or in_nsyms < 2, is dropped: no enc_valid, no count.
//    - err_sym is set and held until reset.
//    - A dropped beat carrying in_last still ends the frame (DRAIN entered).
//  - Without the macro: every beat is issued unchanged and err_sym is tied 0.
// TESTING
//  - Reset: hold reset=0 for 3 cycles with in_valid=1 -> in_ready=0, all outputs 0, busy=0.
//  - Single frame: 3 beats (fl=9690, fh=3202, sym=3, nsyms=10), last on the 3rd, PIPE_DEPTH=4.
//    -> enc_valid on cycles 1-3 after the accepts; flush_req rises 5 cycles after the last accept.
//    -> flush_done pulse -> frame_done 1 cycle later; sym_count=3.
//  - Gapped input: in_valid toggling 1/0 over 4 beats -> enc_valid mirrors with 1-cycle lag; sym_count=4.
//  - Back-to-back frames: next frame's beat presented during FLUSH -> in_ready=0 until IDLE.
//    -> new frame accepted the cycle after frame_done; sym_count restarts at 1.
//  - Abort: reset=0 during DRAIN -> no flush_req, no frame_done; next frame runs normally.
//  - SYMCHK_EN: sym=12, nsyms=10 -> no enc_valid, err_sym=1 sticky, sym_count unchanged.
//    - Same beat with last=1 -> DRAIN/FLUSH still occur.

Source files
------------

// File: rtl/arith_encoder_frame_ctrl.sv
// Frame sequencer in front of the arithmetic encoder: issues one symbol per cycle, drains the
// encoder pipeline after the last symbol, then requests and awaits the flush. Optional macro: ARITH_CTRL_SYMCHK_EN.
module arith_encoder_frame_ctrl #(
    parameter int RANGE_WIDTH  = 16,
    parameter int SYMBOL_WIDTH = 4,
    parameter int PIPE_DEPTH   = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    general_clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RANGE_WIDTH-1:0]  in_fl,
    input  logic [RANGE_WIDTH-1:0]  in_fh,
    input  logic [SYMBOL_WIDTH-1:0] in_symbol,
    input  logic [SYMBOL_WIDTH:0]   in_nsyms,
    input  logic                    in_last,
    output logic                    enc_valid,
    output logic [RANGE_WIDTH-1:0]  enc_fl,
    output logic [RANGE_WIDTH-1:0]  enc_fh,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol,
    output logic [SYMBOL_WIDTH:0]   enc_nsyms,
    output logic                    flush_req,
    input  logic                    flush_done,
    output logic                    frame_done,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    sym_count,
    output logic                    err_sym
);

    // state | meaning
    // IDLE  | waiting for the first beat of a frame
    // RUN   | issuing beats, one per accept
    // DRAIN | last beat seen, waiting PIPE_DEPTH cycles for the encoder pipeline
    // FLUSH | flush_req held high until flush_done
    // DONE  | frame_done pulse, back to IDLE next cycle
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0]           DRAIN_LOAD = 4'(PIPE_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t     state;
    logic [3:0] drain_cnt;
    logic       accept;
    logic       beat_ok;
    logic       issue;

    assign in_ready = reset && ((state == IDLE) || (state == RUN));
    assign accept   = in_valid && in_ready;
    assign issue    = accept && beat_ok;

`ifdef ARITH_CTRL_SYMCHK_EN
    logic drop;

    assign beat_ok = ({1'b0, in_symbol} < in_nsyms) && (in_nsyms >= (SYMBOL_WIDTH+1)'(2));
    assign drop    = accept && !beat_ok;

    always_ff @(posedge general_clk) begin
        if (!reset) begin
            err_sym <= 1'b0;
        end else if (drop) begin
            err_sym <= 1'b1;
        end
    end
`else
    assign beat_ok = 1'b1;
    assign err_sym = 1'b0;
`endif

    always_ff @(posedge general_clk) begin
        if (!reset) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            enc_valid  <= 1'b0;
            enc_fl     <= '0;
            enc_fh     <= '0;
            enc_symbol <= '0;
            enc_nsyms  <= '0;
            flush_req  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            sym_count  <= '0;
        end else begin
            enc_valid  <= issue;
            frame_done <= 1'b0;
            if (issue) begin
                enc_fl     <= in_fl;
                enc_fh     <= in_fh;
                enc_symbol <= in_symbol;
                enc_nsyms  <= in_nsyms;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        sym_count <= issue ? CNT_ONE : '0;
                        busy      <= 1'b1;
                        if (in_last) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (issue && (sym_count != CNT_MAX)) begin
                            sym_count <= sym_count + CNT_ONE;
                        end
                        if (in_last) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    // Zero count means the encoder range/low are stable now.
                    if (drain_cnt == 4'd0) begin
                        state     <= FLUSH;
                        flush_req <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                FLUSH: begin
                    if (flush_done) begin
                        state      <= DONE;
                        flush_req  <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    flush_req <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_encoder_frame_ctrl.sv
// Directed self-checking bench for arith_encoder_frame_ctrl (PIPE_DEPTH=4).
module tb_arith_encoder_frame_ctrl;

    logic        general_clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_fl = '0;
    logic [15:0] in_fh = '0;
    logic [3:0]  in_symbol = '0;
    logic [4:0]  in_nsyms = '0;
    logic        in_last = 1'b0;
    logic        enc_valid;
    logic [15:0] enc_fl;
    logic [15:0] enc_fh;
    logic [3:0]  enc_symbol;
    logic [4:0]  enc_nsyms;
    logic        flush_req;
    logic        flush_done = 1'b0;
    logic        frame_done;
    logic        busy;
    logic [15:0] sym_count;
    logic        err_sym;

    int checks = 0;
    int failures = 0;

    arith_encoder_frame_ctrl #(
        .RANGE_WIDTH(16), .SYMBOL_WIDTH(4), .PIPE_DEPTH(4), .CNT_WIDTH(16)
    ) dut (
        .general_clk(general_clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fl(in_fl), .in_fh(in_fh), .in_symbol(in_symbol), .in_nsyms(in_nsyms), .in_last(in_last),
        .enc_valid(enc_valid), .enc_fl(enc_fl), .enc_fh(enc_fh), .enc_symbol(enc_symbol), .enc_nsyms(enc_nsyms),
        .flush_req(flush_req), .flush_done(flush_done), .frame_done(frame_done),
        .busy(busy), .sym_count(sym_count), .err_sym(err_sym)
    );

    always #5 general_clk = ~general_clk;

    task automatic step();
        @(posedge general_clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [15:0] fl, input logic [15:0] fh,
                            input logic [3:0] sym, input logic [4:0] ns, input logic last);
        in_valid  = v;
        in_fl     = fl;
        in_fh     = fh;
        in_symbol = sym;
        in_nsyms  = ns;
        in_last   = last;
    endtask

    // Steps until flush_req rises; n is the number of cycles taken (30 = gave up).
    task automatic wait_flush(output int n);
        n = 0;
        while (!flush_req && n < 30) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_beat(1'b1, 16'hFFFF, 16'hFFFF, 4'hF, 5'h1F, 1'b1);
        flush_done = 1'b1;
        repeat (3) step();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if ({enc_valid, busy, flush_req, frame_done, err_sym} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b want 00000", {enc_valid, busy, flush_req, frame_done, err_sym});
        end
        checks++;
        if ({enc_fl, enc_fh, enc_symbol, enc_nsyms, sym_count} !== '0) begin
            failures++; $display("FAIL reset_data: got fl=%0d fh=%0d sym=%0d ns=%0d cnt=%0d want all 0",
                                 enc_fl, enc_fh, enc_symbol, enc_nsyms, sym_count);
        end
        set_beat(1'b0, '0, '0, '0, '0, 1'b0);
        flush_done = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        int n;
        set_beat(1'b1, 16'd9690, 16'd3202, 4'd3, 5'd10, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL single_idle_ready: got %b want 1", in_ready); end
        step();
        checks++;
        if ({enc_valid, busy} !== 2'b11 || enc_fl !== 16'd9690 || enc_fh !== 16'd3202
            || enc_symbol !== 4'd3 || enc_nsyms !== 5'd10 || sym_count !== 16'd1) begin
            failures++; $display("FAIL single_beat1: got v=%b busy=%b fl=%0d fh=%0d sym=%0d ns=%0d cnt=%0d want 1 1 9690 3202 3 10 1",
                                 enc_valid, busy, enc_fl, enc_fh, enc_symbol, enc_nsyms, sym_count);
        end
        step();
        checks++;
        if (enc_valid !== 1'b1 || sym_count !== 16'd2) begin
            failures++; $display("FAIL single_beat2: got v=%b cnt=%0d want 1 2", enc_valid, sym_count);
        end
        in_last = 1'b1;
        step();
        checks++;
        if (enc_valid !== 1'b1 || sym_count !== 16'd3 || in_ready !== 1'b0) begin
            failures++; $display("FAIL single_beat3: got v=%b cnt=%0d rdy=%b want 1 3 0", enc_valid, sym_count, in_ready);
        end
        set_beat(1'b0, '0, '0, '0, '0, 1'b0);
        wait_flush(n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL single_flush_latency: got %0d want 5", n); end
        checks++;
        if (enc_valid !== 1'b0 || enc_fl !== 16'd9690) begin
            failures++; $display("FAIL single_enc_hold: got v=%b fl=%0d want 0 9690", enc_valid, enc_fl);
        end
        repeat (2) step();
        checks++;
        if (flush_req !== 1'b1 || frame_done !== 1'b0) begin
            failures++; $display("FAIL single_flush_hold: got req=%b done=%b want 1 0", flush_req, frame_done);
        end
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || flush_req !== 1'b0) begin
            failures++; $display("FAIL single_frame_done: got done=%b req=%b want 1 0", frame_done, flush_req);
        end
        step();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || sym_count !== 16'd3) begin
            failures++; $display("FAIL single_idle_after: got done=%b busy=%b cnt=%0d want 0 0 3", frame_done, busy, sym_count);
        end
    endtask

    task automatic test_gapped();
        int n;
        for (int i = 0; i < 8; i++) begin
            set_beat((i % 2) == 0, 16'(1000 + i), 16'(2000 + i), 4'(i), 5'd9, i == 6);
            step();
            checks++;
            if ((i % 2) == 0) begin
                if (enc_valid !== 1'b1 || enc_fl !== 16'(1000 + i) || enc_symbol !== 4'(i)) begin
                    failures++; $display("FAIL gapped_issue[%0d]: got v=%b fl=%0d sym=%0d want 1 %0d %0d",
                                         i, enc_valid, enc_fl, enc_symbol, 1000 + i, i);
                end
            end else begin
                if (enc_valid !== 1'b0 || enc_fl !== 16'(999 + i)) begin
                    failures++; $display("FAIL gapped_idle[%0d]: got v=%b fl=%0d want 0 %0d", i, enc_valid, enc_fl, 999 + i);
                end
            end
        end
        set_beat(1'b0, '0, '0, '0, '0, 1'b0);
        wait_flush(n);
        checks++;
        if (n !== 4) begin failures++; $display("FAIL gapped_flush_latency: got %0d want 4", n); end
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || sym_count !== 16'd4) begin
            failures++; $display("FAIL gapped_done: got done=%b cnt=%0d want 1 4", frame_done, sym_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        set_beat(1'b1, 16'd500, 16'd600, 4'd1, 5'd4, 1'b0);
        step();
        set_beat(1'b1, 16'd501, 16'd601, 4'd2, 5'd4, 1'b1);
        step();
        set_beat(1'b1, 16'd777, 16'd888, 4'd5, 5'd8, 1'b1);
        wait_flush(n);
        checks++;
        if (n !== 5 || sym_count !== 16'd2) begin
            failures++; $display("FAIL b2b_first_frame: got lat=%0d cnt=%0d want 5 2", n, sym_count);
        end
        checks++;
        if (in_ready !== 1'b0 || enc_valid !== 1'b0 || enc_fl !== 16'd501) begin
            failures++; $display("FAIL b2b_blocked_in_flush: got rdy=%b v=%b fl=%0d want 0 0 501", in_ready, enc_valid, enc_fl);
        end
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_done_blocked: got done=%b rdy=%b want 1 0", frame_done, in_ready);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || enc_valid !== 1'b0 || sym_count !== 16'd2) begin
            failures++; $display("FAIL b2b_idle: got rdy=%b v=%b cnt=%0d want 1 0 2", in_ready, enc_valid, sym_count);
        end
        step();
        checks++;
        if (enc_valid !== 1'b1 || enc_fl !== 16'd777 || sym_count !== 16'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_restart: got v=%b fl=%0d cnt=%0d busy=%b want 1 777 1 1",
                                 enc_valid, enc_fl, sym_count, busy);
        end
        set_beat(1'b0, '0, '0, '0, '0, 1'b0);
        wait_flush(n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL b2b_second_latency: got %0d want 5", n); end
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        int n;
        logic seen;
        set_beat(1'b1, 16'd42, 16'd43, 4'd0, 5'd2, 1'b1);
        step();
        set_beat(1'b0, '0, '0, '0, '0, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if ({busy, flush_req, frame_done, enc_valid} !== 4'b0 || sym_count !== 16'd0 || enc_fl !== 16'd0) begin
            failures++; $display("FAIL abort_cleared: got busy=%b req=%b done=%b v=%b cnt=%0d fl=%0d want all 0",
                                 busy, flush_req, frame_done, enc_valid, sym_count, enc_fl);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            flush_done = (i == 3);
            step();
            seen = seen | flush_req | frame_done | busy;
        end
        flush_done = 1'b0;
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_quiet: got activity=%b want 0", seen); end
        set_beat(1'b1, 16'd60, 16'd70, 4'd1, 5'd3, 1'b0);
        step();
        set_beat(1'b1, 16'd61, 16'd71, 4'd2, 5'd3, 1'b1);
        step();
        set_beat(1'b0, '0, '0, '0, '0, 1'b0);
        wait_flush(n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL abort_next_latency: got %0d want 5", n); end
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || sym_count !== 16'd2 || enc_fl !== 16'd61) begin
            failures++; $display("FAIL abort_next_done: got done=%b cnt=%0d fl=%0d want 1 2 61", frame_done, sym_count, enc_fl);
        end
        step();
    endtask

    task automatic test_symchk();
        int n;
`ifdef ARITH_CTRL_SYMCHK_EN
        set_beat(1'b1, 16'd300, 16'd400, 4'd12, 5'd10, 1'b0);
        step();
        checks++;
        if (enc_valid !== 1'b0 || err_sym !== 1'b1 || sym_count !== 16'd0 || busy !== 1'b1) begin
            failures++; $display("FAIL symchk_drop_first: got v=%b err=%b cnt=%0d busy=%b want 0 1 0 1",
                                 enc_valid, err_sym, sym_count, busy);
        end
        set_beat(1'b1, 16'd301, 16'd401, 4'd0, 5'd1, 1'b0);
        step();
        checks++;
        if (enc_valid !== 1'b0 || sym_count !== 16'd0) begin
            failures++; $display("FAIL symchk_small_alphabet: got v=%b cnt=%0d want 0 0", enc_valid, sym_count);
        end
        set_beat(1'b1, 16'd302, 16'd402, 4'd2, 5'd10, 1'b0);
        step();
        checks++;
        if (enc_valid !== 1'b1 || enc_fl !== 16'd302 || sym_count !== 16'd1 || err_sym !== 1'b1) begin
            failures++; $display("FAIL symchk_legal: got v=%b fl=%0d cnt=%0d err=%b want 1 302 1 1",
                                 enc_valid, enc_fl, sym_count, err_sym);
        end
        set_beat(1'b1, 16'd303, 16'd403, 4'd12, 5'd10, 1'b1);
        step();
        checks++;
        if (enc_valid !== 1'b0 || sym_count !== 16'd1 || in_ready !== 1'b0 || enc_fl !== 16'd302) begin
            failures++; $display("FAIL symchk_drop_last: got v=%b cnt=%0d rdy=%b fl=%0d want 0 1 0 302",
                                 enc_valid, sym_count, in_ready, enc_fl);
        end
        set_beat(1'b0, '0, '0, '0, '0, 1'b0);
        wait_flush(n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL symchk_flush_latency: got %0d want 5", n); end
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        step();
        checks++;
        if (err_sym !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL symchk_sticky: got err=%b busy=%b want 1 0", err_sym, busy);
        end
`else
        set_beat(1'b1, 16'd123, 16'd456, 4'd12, 5'd10, 1'b1);
        step();
        checks++;
        if (enc_valid !== 1'b1 || enc_symbol !== 4'd12 || enc_fl !== 16'd123 || sym_count !== 16'd1 || err_sym !== 1'b0) begin
            failures++; $display("FAIL nochk_passthru: got v=%b sym=%0d fl=%0d cnt=%0d err=%b want 1 12 123 1 0",
                                 enc_valid, enc_symbol, enc_fl, sym_count, err_sym);
        end
        set_beat(1'b0, '0, '0, '0, '0, 1'b0);
        wait_flush(n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL nochk_flush_latency: got %0d want 5", n); end
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        step();
        checks++;
        if (err_sym !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL nochk_err_tied: got err=%b busy=%b want 0 0", err_sym, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gapped();
        test_back_to_back();
        test_abort();
        test_symchk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
